// File: rtl/dd_au_seq.sv
// Instruction sequencer feeding the combinational DD_AU unit: fetches 1-2 byte
// instructions, drives registered AU operands for one EXEC cycle, writes results back.
module dd_au_seq #(
  parameter int unsigned DW         = 8,
  parameter int unsigned AW         = 8,
  parameter int unsigned START_ADDR = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic [AW-1:0] pm_addr,
  output logic          pm_rd,
  input  logic [7:0]    pm_data,
  input  logic          pm_valid,
  output logic          au_en,
  output logic [3:0]    ac,
  output logic [DW-1:0] au_a,
  output logic [DW-1:0] au_b,
  input  logic [DW-1:0] au_t,
  input  logic          au_gf,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  output logic          busy,
  output logic          halted
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_FETCH2, S_EXEC, S_HALT
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'b1000;
  localparam logic [3:0] OP_SUB  = 4'b1001;
  localparam logic [3:0] OP_MOV  = 4'b0100;
  localparam logic [3:0] OP_LDI  = 4'b0101;
  localparam logic [3:0] OP_OUT  = 4'b1101;
  localparam logic [3:0] OP_JGF  = 4'b0010;
  localparam logic [3:0] OP_HALT = 4'b1111;
  localparam logic [AW-1:0] START_PC = AW'(START_ADDR);

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [7:0]    ir_q, ir_d;
  logic [DW-1:0] rf_q [4];
  logic          gf_q;
  logic          au_en_q, au_en_d;
  logic [3:0]    ac_q, ac_d;
  logic [DW-1:0] au_a_q, au_a_d;
  logic [DW-1:0] au_b_q, au_b_d;
  logic [DW-1:0] out_data_q;
  logic          out_valid_q;

  logic [3:0] op;
  logic [1:0] rd, rs;

  assign op = ir_q[7:4];
  assign rd = ir_q[3:2];
  assign rs = ir_q[1:0];

  // AU drive values are computed for the cycle being entered, so the
  // registered outputs are valid exactly during the EXEC cycle.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    au_en_d = 1'b0;
    ac_d    = '0;
    au_a_d  = '0;
    au_b_d  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = START_PC;
        end
      end
      S_FETCH: begin
        if (pm_valid) begin
          ir_d    = pm_data;
          pc_d    = pc_q + AW'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        unique case (op)
          OP_LDI, OP_JGF: state_d = S_FETCH2;
          OP_HALT:        state_d = S_HALT;
          OP_ADD, OP_SUB, OP_MOV, OP_OUT: begin
            state_d = S_EXEC;
            au_en_d = 1'b1;
            ac_d    = op;
            au_a_d  = rf_q[rs];
            au_b_d  = rf_q[rd];
          end
          default:        state_d = S_FETCH;
        endcase
      end
      S_FETCH2: begin
        if (pm_valid) begin
          pc_d = pc_q + AW'(1);
          if (op == OP_JGF) begin
            state_d = S_FETCH;
            if (gf_q) pc_d = AW'(pm_data);
          end else begin
            state_d = S_EXEC;
            au_en_d = 1'b1;
            ac_d    = op;
            au_a_d  = DW'(pm_data);
            au_b_d  = rf_q[rd];
          end
        end
      end
      S_EXEC: state_d = S_FETCH;
      S_HALT: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = START_PC;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= START_PC;
      ir_q        <= '0;
      gf_q        <= 1'b0;
      au_en_q     <= 1'b0;
      ac_q        <= '0;
      au_a_q      <= '0;
      au_b_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) rf_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      au_en_q     <= au_en_d;
      ac_q        <= ac_d;
      au_a_q      <= au_a_d;
      au_b_q      <= au_b_d;
      out_valid_q <= (state_q == S_EXEC) && (op == OP_OUT);
      if (state_q == S_EXEC) begin
        if (op == OP_OUT) out_data_q <= au_t;
        else              rf_q[rd]   <= au_t;
        if (op == OP_SUB) gf_q <= au_gf;
      end
    end
  end

  assign pm_addr   = pc_q;
  assign pm_rd     = (state_q == S_FETCH) || (state_q == S_FETCH2);
  assign au_en     = au_en_q;
  assign ac        = ac_q;
  assign au_a      = au_a_q;
  assign au_b      = au_b_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_dd_au_seq.sv
// Bench for dd_au_seq: AU and program memory models, plus an instruction-level
// interpreter predicting fetch addresses, AU transactions, OUT values and cycle counts.
module tb_dd_au_seq;

  logic       clk, rst_n, start;
  logic [7:0] pm_addr, pm_data;
  logic       pm_rd, pm_valid;
  logic       au_en, au_gf;
  logic [3:0] ac;
  logic [7:0] au_a, au_b, au_t;
  logic [7:0] out_data;
  logic       out_valid, busy, halted;

  int checks = 0;
  int failures = 0;

  logic [7:0]  mem [256];
  logic [7:0]  m_reg [4];
  logic        m_gf;
  int          fetch_delay = 0;
  bit          mon_en = 0;
  int          viol = 0;
  logic [19:0] obs_fetch[$], exp_fetch[$], obs_exec[$], exp_exec[$], obs_out[$], exp_out[$];

  dd_au_seq #(.DW(8), .AW(8), .START_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .pm_addr(pm_addr), .pm_rd(pm_rd), .pm_data(pm_data), .pm_valid(pm_valid),
    .au_en(au_en), .ac(ac), .au_a(au_a), .au_b(au_b), .au_t(au_t), .au_gf(au_gf),
    .out_data(out_data), .out_valid(out_valid), .busy(busy), .halted(halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // AU: add, reverse subtract, pass-through; gf = b > a. Junk when disabled.
  always_comb begin
    if (!au_en) begin
      au_t  = 8'hA5;
      au_gf = 1'b1;
    end else begin
      case (ac)
        4'h8:    au_t = au_a + au_b;
        4'h9:    au_t = au_b - au_a;
        default: au_t = au_a;
      endcase
      au_gf = au_b > au_a;
    end
  end

  // Program memory: answers after fetch_delay wait cycles; noise when idle.
  initial begin
    int wcnt;
    bit gave;
    wcnt = 0;
    gave = 0;
    pm_valid = 1'b0;
    pm_data  = '0;
    forever begin
      @(negedge clk);
      if (pm_rd) begin
        if (gave) wcnt = 0;
        if (wcnt >= fetch_delay) begin
          pm_valid = 1'b1;
          pm_data  = mem[pm_addr];
          gave     = 1;
        end else begin
          pm_valid = 1'b0;
          pm_data  = 8'($urandom);
          gave     = 0;
          wcnt++;
        end
      end else begin
        gave = 0;
        wcnt = 0;
        pm_valid = 1'($urandom_range(0, 1));
        pm_data  = 8'($urandom);
      end
    end
  end

  // Observer, sampling late in each cycle.
  initial begin
    bit prev_en, prev_ov, hold;
    logic [7:0] hold_addr;
    prev_en = 0; prev_ov = 0; hold = 0; hold_addr = '0;
    forever begin
      @(posedge clk);
      #8;
      if (mon_en) begin
        if (hold && (!pm_rd || pm_addr != hold_addr)) viol++;
        hold = pm_rd && !pm_valid;
        hold_addr = pm_addr;
        if (pm_rd && pm_valid) obs_fetch.push_back({12'h0, pm_addr});
        if (au_en) begin
          obs_exec.push_back({ac, au_a, au_b});
          if (prev_en) viol++;
        end else if (ac != 0 || au_a != 0 || au_b != 0) viol++;
        if (out_valid) begin
          obs_out.push_back({12'h0, out_data});
          if (prev_ov) viol++;
        end
        prev_en = au_en;
        prev_ov = out_valid;
      end else begin
        prev_en = 0; prev_ov = 0; hold = 0;
      end
    end
  end

  function automatic int q_diff(input logic [19:0] a[$], input logic [19:0] b[$]);
    if (a.size() != b.size()) return 1000 + a.size();
    foreach (a[i]) if (a[i] !== b[i]) return i;
    return -1;
  endfunction

  task automatic fill_halt();
    for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = '0;
    m_gf = 1'b0;
  endtask

  // Instruction-level interpreter over mem; register state persists across runs.
  task automatic model_run(input int d, output int cyc);
    logic [7:0] pc, ir, imm, a, b, t;
    logic [3:0] op;
    logic [1:0] rd, rs;
    pc = 8'h00;
    cyc = 0;
    imm = '0;
    for (int step = 0; step < 500; step++) begin
      exp_fetch.push_back({12'h0, pc});
      ir = mem[pc];
      pc = pc + 8'd1;
      cyc += d + 2;
      op = ir[7:4]; rd = ir[3:2]; rs = ir[1:0];
      if (op == 4'hF) break;
      if (op == 4'h5 || op == 4'h2) begin
        exp_fetch.push_back({12'h0, pc});
        imm = mem[pc];
        pc = pc + 8'd1;
        cyc += d + 1;
      end
      a = m_reg[rs];
      b = m_reg[rd];
      if (op == 4'h2) begin
        if (m_gf) pc = imm;
      end else if (op == 4'h8 || op == 4'h9 || op == 4'h4 || op == 4'h5 || op == 4'hD) begin
        if (op == 4'h5) a = imm;
        t = (op == 4'h8) ? a + b : (op == 4'h9) ? b - a : a;
        exp_exec.push_back({op, a, b});
        cyc += 1;
        if (op == 4'hD) exp_out.push_back({12'h0, t});
        else m_reg[rd] = t;
        if (op == 4'h9) m_gf = b > a;
      end
    end
  endtask

  task automatic run_prog(input string name, input int d, input bit poke);
    int exp_cyc, n, k;
    fetch_delay = d;
    obs_fetch.delete(); exp_fetch.delete();
    obs_exec.delete();  exp_exec.delete();
    obs_out.delete();   exp_out.delete();
    viol = 0;
    model_run(d, exp_cyc);
    mon_en = 1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!halted && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
      if (poke && n == 1) start = 1'b1;
      if (n == 2) start = 1'b0;
    end
    start = 1'b0;
    repeat (2) @(posedge clk);
    #9;
    mon_en = 0;
    checks++;
    if (n !== exp_cyc) begin failures++; $display("FAIL %s cycles: got %0d want %0d", name, n, exp_cyc); end
    checks++;
    if (halted !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL %s halt_state: halted=%0b busy=%0b want 1/0", name, halted, busy);
    end
    k = q_diff(obs_fetch, exp_fetch);
    checks++;
    if (k !== -1) begin failures++; $display("FAIL %s fetch_seq: got %0d fetches want %0d (diff %0d)", name, obs_fetch.size(), exp_fetch.size(), k); end
    k = q_diff(obs_exec, exp_exec);
    checks++;
    if (k !== -1) begin failures++; $display("FAIL %s au_txn: got %0d txns want %0d (diff %0d)", name, obs_exec.size(), exp_exec.size(), k); end
    k = q_diff(obs_out, exp_out);
    checks++;
    if (k !== -1) begin failures++; $display("FAIL %s out_seq: got %0d outs want %0d (diff %0d)", name, obs_out.size(), exp_out.size(), k); end
    checks++;
    if (viol !== 0) begin failures++; $display("FAIL %s protocol: got %0d violations want 0", name, viol); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({pm_addr, pm_rd, au_en, ac, au_a, au_b, out_data, out_valid, busy, halted} !== '0) begin
      failures++; $display("FAIL reset_outputs: got %h want 0", {pm_addr, pm_rd, au_en, ac, au_a, au_b, out_data, out_valid, busy, halted});
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({pm_addr, pm_rd, au_en, busy, halted} !== '0) begin
      failures++; $display("FAIL idle_after_reset: got %h want 0", {pm_addr, pm_rd, au_en, busy, halted});
    end
  endtask

  task automatic test_basic_prog();
    fill_halt();
    {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5], mem[6]} = {8'h50, 8'h05, 8'h54, 8'h03, 8'h84, 8'hD1, 8'hF0};
    run_prog("basic", 0, 0);
    checks++;
    if (obs_out.size() != 1 || obs_out[0] !== 20'h08) begin
      failures++; $display("FAIL basic_out: got %0d values first %h want 1 value 08", obs_out.size(), obs_out.size() ? obs_out[0] : 20'h0);
    end
  endtask

  task automatic test_add_wrap();
    fill_halt();
    {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5], mem[6]} = {8'h50, 8'hC8, 8'h54, 8'h64, 8'h81, 8'hD0, 8'hF0};
    run_prog("add_wrap", 0, 1);
    checks++;
    if (obs_out.size() != 1 || obs_out[0] !== 20'h2C) begin
      failures++; $display("FAIL add_wrap_out: got %0d values first %h want 2C", obs_out.size(), obs_out.size() ? obs_out[0] : 20'h0);
    end
    checks++;
    if (obs_exec.size() != 4 || obs_exec[2][19:16] !== 4'b1000) begin
      failures++; $display("FAIL add_wrap_ac: got %0d txns want ADD as 3rd of 4", obs_exec.size());
    end
  endtask

  task automatic test_jgf();
    fill_halt();
    {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5], mem[6], mem[7]} = {8'h50, 8'h01, 8'h54, 8'h09, 8'h94, 8'h20, 8'h40, 8'hD1};
    mem[8'h40] = 8'hD0;
    run_prog("jgf_taken", 0, 0);
    checks++;
    if (obs_fetch.size() < 8 || obs_fetch[7] !== 20'h40) begin
      failures++; $display("FAIL jgf_taken_addr: got %0d fetches want 8th at 40", obs_fetch.size());
    end
    {mem[1], mem[3]} = {8'h09, 8'h01};
    run_prog("jgf_not_taken", 1, 1);
    checks++;
    if (obs_out.size() != 1 || obs_out[0] !== 20'hF8) begin
      failures++; $display("FAIL jgf_nt_out: got %0d values want F8", obs_out.size());
    end
  endtask

  task automatic test_fetch_wait();
    fill_halt();
    {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5], mem[6]} = {8'h50, 8'h05, 8'h54, 8'h03, 8'h84, 8'hD1, 8'hF0};
    run_prog("fetch_wait", 3, 1);
  endtask

  task automatic test_pc_wrap_halt();
    fill_halt();
    mem[0] = 8'h90;
    run_prog("clear_gf", 0, 0);
    fill_halt();
    {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5], mem[6], mem[7], mem[8]} =
      {8'h20, 8'h10, 8'h50, 8'h03, 8'h54, 8'h00, 8'h91, 8'h20, 8'hFE};
    {mem[8'hFE], mem[8'hFF], mem[8'h10]} = {8'h48, 8'hD2, 8'hD0};
    run_prog("pc_wrap", 0, 0);
    checks++;
    if (obs_out.size() != 2 || obs_out[0] !== 20'h03 || obs_out[1] !== 20'h03) begin
      failures++; $display("FAIL pc_wrap_out: got %0d values want 03 03", obs_out.size());
    end
    run_prog("restart", 2, 0);
  endtask

  task automatic test_reset_in_fetch2();
    int n;
    bit found;
    fill_halt();
    {mem[0], mem[1]} = {8'h5C, 8'h77};
    fetch_delay = 3;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    found = 0;
    for (n = 0; n < 30 && !found; n++) begin
      @(posedge clk);
      #1;
      if (pm_rd && pm_addr == 8'h01) found = 1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL fetch2_reach: got no FETCH2 at 01 want reached"); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({pm_addr, pm_rd, au_en, ac, au_a, au_b, out_data, out_valid, busy, halted} !== '0) begin
      failures++; $display("FAIL async_reset_outputs: got %h want 0", {pm_addr, pm_rd, au_en, ac, au_a, au_b, out_data, out_valid, busy, halted});
    end
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    fill_halt();
    mem[0] = 8'hD3;
    run_prog("after_reset", 0, 0);
    checks++;
    if (obs_out.size() != 1 || obs_out[0] !== 20'h00) begin
      failures++; $display("FAIL reset_reg3: got %0d values want single 00", obs_out.size());
    end
  endtask

  task automatic test_random();
    logic [3:0] nops [9] = '{4'h0, 4'h1, 4'h3, 4'h6, 4'h7, 4'hA, 4'hB, 4'hC, 4'hE};
    int starts[$];
    int jpos[$], jidx[$];
    int addr;
    logic [3:0] op;
    logic [3:0] regs;
    for (int p = 0; p < 8; p++) begin
      fill_halt();
      starts.delete(); jpos.delete(); jidx.delete();
      addr = 0;
      for (int i = 0; i < 10; i++) begin
        starts.push_back(addr);
        regs = 4'($urandom);
        case ($urandom_range(0, 6))
          0: op = 4'h8;
          1: op = 4'h9;
          2: op = 4'h4;
          3: op = 4'h5;
          4: op = 4'hD;
          5: op = 4'h2;
          default: op = nops[$urandom_range(0, 8)];
        endcase
        mem[addr] = {op, regs};
        addr++;
        if (op == 4'h5) begin mem[addr] = 8'($urandom); addr++; end
        if (op == 4'h2) begin jpos.push_back(addr); jidx.push_back(i); addr++; end
      end
      starts.push_back(addr);
      {mem[addr], mem[addr+1], mem[addr+2], mem[addr+3]} = {8'hD0, 8'hD1, 8'hD2, 8'hD3};
      foreach (jpos[j]) mem[jpos[j]] = 8'(starts[$urandom_range(jidx[j] + 1, 10)]);
      run_prog($sformatf("random%0d", p), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    start = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_basic_prog();
    test_add_wrap();
    test_jgf();
    test_fetch_wait();
    test_pc_wrap_halt();
    test_reset_in_fetch2();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
